// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline latch: payload, valid and iterative-op carry,
// with stall/flush handling, stage state and saturating occupancy counters.
module pipe_stage_reg #(
  parameter int DATA_W  = 128,
  parameter int CARRY_W = 66,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [CARRY_W-1:0] carry_i,
  input  logic               cnt_clr_i,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [CARRY_W-1:0] carry_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   stall_cycles_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  // Handshake: there is no valid/ready pair here. in_valid_i qualifies
  // in_data_i; the stall vector is the only backpressure, and a stage
  // accepts new input exactly when its own stall bit is low.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_BUBBLE  = 3'd2,
    ACT_ADVANCE = 3'd3,
    ACT_HOLD    = 3'd4
  } action_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic    s_up;
  logic    s_dn;
  action_t action;
  state_t  state_q;

  // The last stage has no downstream stall bit, so a stall there is a bubble.
  generate
    if (STAGE >= STALL_W) begin : g_bad_stage
      $fatal(1, "pipe_stage_reg: STAGE must be below STALL_W");
      assign s_up = 1'b0;
      assign s_dn = 1'b0;
    end else if (STAGE == STALL_W - 1) begin : g_last_stage
      assign s_up = stall[STAGE];
      assign s_dn = 1'b0;
    end else begin : g_mid_stage
      assign s_up = stall[STAGE];
      assign s_dn = stall[STAGE+1];
    end
  endgenerate

  always_comb begin
    action = ACT_HOLD;
    if (Rst_n)
      action = ACT_RESET;
    else if (flush_i)
      action = ACT_FLUSH;
    else if (s_up && !s_dn)
      action = ACT_BUBBLE;
    else if (!s_up)
      action = ACT_ADVANCE;
    else
      action = ACT_HOLD;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Payload, valid, carry and stage state.
  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET, ACT_FLUSH: begin
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        carry_o     <= '0;
        state_q     <= ST_EMPTY;
      end
      ACT_BUBBLE: begin
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        carry_o     <= carry_i;
        state_q     <= ST_EMPTY;
      end
      ACT_ADVANCE: begin
        out_valid_o <= in_valid_i;
        out_data_o  <= in_valid_i ? in_data_i : '0;
        carry_o     <= '0;
        state_q     <= in_valid_i ? ST_FULL : ST_EMPTY;
      end
      default: begin
        carry_o <= carry_i;
        state_q <= (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
      end
    endcase
  end

  // Occupancy counters depend only on the action, never on the payload.
  always_ff @(posedge clk) begin
    if (Rst_n || cnt_clr_i) begin
      stall_cycles_o <= '0;
      bubble_cnt_o   <= '0;
      flush_cnt_o    <= '0;
    end else begin
      case (action)
        ACT_FLUSH: flush_cnt_o <= sat_inc(flush_cnt_o);
        ACT_BUBBLE: begin
          bubble_cnt_o   <= sat_inc(bubble_cnt_o);
          stall_cycles_o <= sat_inc(stall_cycles_o);
        end
        ACT_HOLD: stall_cycles_o <= sat_inc(stall_cycles_o);
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance, a 3-bit-counter
// instance and a last-stage instance share one stimulus stream.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 66;
  localparam int SW = 6;

  logic          clk;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] carry_in;
  logic          cnt_clr;

  logic          m_valid, s_valid, t_valid;
  logic [DW-1:0] m_data, s_data, t_data;
  logic [CW-1:0] m_carry, s_carry, t_carry;
  logic [1:0]    m_state, s_state, t_state;
  logic [31:0]   m_stall_cyc, m_bubble, m_flush;
  logic [2:0]    s_stall_cyc, s_bubble, s_flush;
  logic [31:0]   t_stall_cyc, t_bubble, t_flush;

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CARRY_W(CW), .STALL_W(SW), .STAGE(3), .CNT_W(32)) u_main (
    .clk(clk), .Rst_n(rst), .stall(stall), .flush_i(flush), .in_valid_i(in_valid),
    .in_data_i(in_data), .carry_i(carry_in), .cnt_clr_i(cnt_clr),
    .out_valid_o(m_valid), .out_data_o(m_data), .carry_o(m_carry), .state_o(m_state),
    .stall_cycles_o(m_stall_cyc), .bubble_cnt_o(m_bubble), .flush_cnt_o(m_flush)
  );

  pipe_stage_reg #(.DATA_W(DW), .CARRY_W(CW), .STALL_W(SW), .STAGE(3), .CNT_W(3)) u_sat (
    .clk(clk), .Rst_n(rst), .stall(stall), .flush_i(flush), .in_valid_i(in_valid),
    .in_data_i(in_data), .carry_i(carry_in), .cnt_clr_i(cnt_clr),
    .out_valid_o(s_valid), .out_data_o(s_data), .carry_o(s_carry), .state_o(s_state),
    .stall_cycles_o(s_stall_cyc), .bubble_cnt_o(s_bubble), .flush_cnt_o(s_flush)
  );

  pipe_stage_reg #(.DATA_W(DW), .CARRY_W(CW), .STALL_W(SW), .STAGE(5), .CNT_W(32)) u_top (
    .clk(clk), .Rst_n(rst), .stall(stall), .flush_i(flush), .in_valid_i(in_valid),
    .in_data_i(in_data), .carry_i(carry_in), .cnt_clr_i(cnt_clr),
    .out_valid_o(t_valid), .out_data_o(t_data), .carry_o(t_carry), .state_o(t_state),
    .stall_cycles_o(t_stall_cyc), .bubble_cnt_o(t_bubble), .flush_cnt_o(t_flush)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks run there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [SW-1:0] st, input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c);
    stall    = st;
    in_valid = v;
    in_data  = d;
    carry_in = c;
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] ones;
    total    = 0;
    bad      = 0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    a5       = {16{8'hA5}};
    ones     = {DW{1'b1}};

    // Reset with live-looking input.
    rst = 1'b1;
    drive(6'b000000, 1'b1, ones, {CW{1'b1}});
    step();
    step();
    check("rst_valid", 128'(m_valid), 128'(0));
    check("rst_data", m_data, 128'(0));
    check("rst_carry", 128'(m_carry), 128'(0));
    check("rst_state", 128'(m_state), 128'(0));
    check("rst_stall_cyc", 128'(m_stall_cyc), 128'(0));
    check("rst_bubble", 128'(m_bubble), 128'(0));
    check("rst_flush", 128'(m_flush), 128'(0));

    // First advance.
    rst = 1'b0;
    drive(6'b000000, 1'b1, a5, 66'd0);
    step();
    check("adv_data", m_data, a5);
    check("adv_valid", 128'(m_valid), 128'(1));
    check("adv_state", 128'(m_state), 128'(1));
    check("adv_carry", 128'(m_carry), 128'(0));

    // Bubbles: stall[3]=1, stall[4]=0; carry follows one cycle late.
    for (int i = 1; i <= 3; i++) begin
      drive(6'b001111, 1'b1, a5, CW'(i));
      step();
      check("bub_carry", 128'(m_carry), 128'(i));
      check("bub_valid", 128'(m_valid), 128'(0));
      check("bub_data", m_data, 128'(0));
    end
    check("bub_state", 128'(m_state), 128'(0));
    check("bub_cnt", 128'(m_bubble), 128'(3));
    check("bub_stall_cyc", 128'(m_stall_cyc), 128'(3));

    // Load 0x1234, then hold two cycles with changing input.
    drive(6'b000000, 1'b1, 128'h1234, 66'd0);
    step();
    check("load_state", 128'(m_state), 128'(1));
    drive(6'b011111, 1'b1, 128'h9999, 66'd10);
    step();
    check("hold1_data", m_data, 128'h1234);
    check("hold1_valid", 128'(m_valid), 128'(1));
    check("hold1_state", 128'(m_state), 128'(2));
    check("hold1_carry", 128'(m_carry), 128'(10));
    drive(6'b011111, 1'b0, 128'h7777, 66'd11);
    step();
    check("hold2_data", m_data, 128'h1234);
    check("hold2_carry", 128'(m_carry), 128'(11));
    check("hold2_state", 128'(m_state), 128'(2));
    check("hold2_stall_cyc", 128'(m_stall_cyc), 128'(5));
    check("hold_bubble_same", 128'(m_bubble), 128'(3));
    drive(6'b000000, 1'b1, 128'h5678, 66'd20);
    step();
    check("rel_data", m_data, 128'h5678);
    check("rel_state", 128'(m_state), 128'(1));
    check("rel_carry", 128'(m_carry), 128'(0));

    // Flush wins over a hold while carry is nonzero.
    drive(6'b011111, 1'b1, 128'h5678, 66'h33);
    step();
    check("prefl_carry", 128'(m_carry), 128'h33);
    check("prefl_stall_cyc", 128'(m_stall_cyc), 128'(6));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 128'(m_valid), 128'(0));
    check("fl_data", m_data, 128'(0));
    check("fl_carry", 128'(m_carry), 128'(0));
    check("fl_state", 128'(m_state), 128'(0));
    check("fl_cnt", 128'(m_flush), 128'(1));
    check("fl_stall_cyc", 128'(m_stall_cyc), 128'(6));

    // Reset during a hold, with clear asserted too.
    drive(6'b000000, 1'b1, 128'h42, 66'd0);
    step();
    drive(6'b011111, 1'b1, 128'h42, 66'd5);
    step();
    rst     = 1'b1;
    cnt_clr = 1'b1;
    step();
    rst     = 1'b0;
    cnt_clr = 1'b0;
    check("midrst_state", 128'(m_state), 128'(0));
    check("midrst_carry", 128'(m_carry), 128'(0));
    check("midrst_flush", 128'(m_flush), 128'(0));
    check("midrst_sat_bub", 128'(s_bubble), 128'(0));

    // Saturation of the 3-bit counter.
    for (int i = 0; i < 9; i++) begin
      drive(6'b001111, 1'b0, 128'(0), CW'(i));
      step();
    end
    check("sat_bubble", 128'(s_bubble), 128'(7));
    check("sat_stall_cyc", 128'(s_stall_cyc), 128'(7));
    check("wide_bubble", 128'(m_bubble), 128'(9));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_sat_bubble", 128'(s_bubble), 128'(0));
    check("clr_main_bubble", 128'(m_bubble), 128'(0));
    check("clr_main_stall", 128'(m_stall_cyc), 128'(0));
    step();
    check("after_clr_bubble", 128'(s_bubble), 128'(1));

    // Last stage: stall[5] alone is a bubble there, an advance for stage 3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(6'b000000, 1'b1, 128'hAB, 66'd0);
    step();
    check("top_load", t_data, 128'hAB);
    drive(6'b100000, 1'b1, 128'hCD, 66'd9);
    step();
    check("top_bub_data", t_data, 128'(0));
    check("top_bub_cnt", 128'(t_bubble), 128'(1));
    check("top_bub_carry", 128'(t_carry), 128'(9));
    check("top_bub_state", 128'(t_state), 128'(0));
    check("mid_adv_data", m_data, 128'hCD);
    drive(6'b000000, 1'b0, ones, 66'd0);
    step();
    check("inv_top_data", t_data, 128'(0));
    check("inv_top_valid", 128'(t_valid), 128'(0));
    check("inv_main_data", m_data, 128'(0));
    check("inv_main_state", 128'(m_state), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that generalises the inter-stage latch (ID/EX, EX/MEM, MEM/WB) into one block. It carries an opaque payload plus a valid bit and a multi-cycle carry field (e.g. {hilo_temp, cnt} for iterative MADD/MSUB/DIV). It applies the shared stall vector and the exception flush, and adds valid tracking, a stage state output and saturating occupancy counters. One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 128, payload width in bits (all forwarded control/data fields, concatenated)
CARRY_W, 66, multi-cycle carry width (default = 64-bit hilo_temp + 2-bit cnt)
STALL_W, 6, width of the global stall vector
STAGE, 3, index of this stage's stall bit; downstream stall bit is STAGE+1
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
Rst_n  in  1  reset; synchronous, active-high (asserted = 1'b1, matches RstEnable)
stall  in  STALL_W  global stall vector from the controller
flush_i  in  1  exception flush
in_valid_i  in  1  upstream instruction valid
in_data_i  in  DATA_W  upstream payload
carry_i  in  CARRY_W  multi-cycle carry from the upstream execute logic
cnt_clr_i  in  1  synchronous clear of the performance counters
out_valid_o  out  1  registered valid
out_data_o  out  DATA_W  registered payload
carry_o  out  CARRY_W  registered carry, fed back to the upstream stage
state_o  out  2  0 = EMPTY, 1 = FULL, 2 = HELD
stall_cycles_o  out  CNT_W  cycles spent in bubble or hold
bubble_cnt_o  out  CNT_W  bubbles inserted
flush_cnt_o  out  CNT_W  flushes taken

Behaviour:
- Definitions: s_up = stall[STAGE]. s_dn = stall[STAGE+1], or 0 when STAGE == STALL_W-1. Elaboration must fail if STAGE >= STALL_W.
- Action per cycle, first match wins:
  - RESET (Rst_n=1)
  - FLUSH (flush_i=1)
  - BUBBLE (s_up=1, s_dn=0)
  - ADVANCE (s_up=0)
  - HOLD (s_up=1, s_dn=1)
- RESET: out_valid_o=0, out_data_o=0, carry_o=0, state_o=EMPTY, all counters=0. Applies mid-operation, including during HOLD or a multi-cycle carry sequence.
- FLUSH: out_valid_o=0, out_data_o=0, carry_o=0 (the carry is cleared; an interrupted iterative op restarts), state EMPTY. flush_cnt increments. Flush overrides any stall value.
- BUBBLE: out_valid_o=0, out_data_o=0, carry_o<=carry_i, state EMPTY. bubble_cnt and stall_cycles increment.
- ADVANCE:
  - out_valid_o<=in_valid_i and carry_o<=0.
  - out_data_o<=in_data_i when in_valid_i=1; otherwise 0, so an invalid entry is always all-zero.
  - state FULL if in_valid_i=1, else EMPTY.
- HOLD: out_valid_o and out_data_o unchanged; carry_o<=carry_i. State: FULL or HELD -> HELD; EMPTY stays EMPTY. stall_cycles increments.
- State transitions:
  - EMPTY -> FULL on ADVANCE with valid.
  - FULL -> HELD on HOLD.
  - HELD -> FULL or EMPTY on ADVANCE, per in_valid_i.
  - Any state -> EMPTY on RESET, FLUSH or BUBBLE.
- Latency: 1 cycle input to output on ADVANCE; 0 throughput loss without stalls.
- Counters:
  - Each saturates at all-ones; it does not wrap.
  - cnt_clr_i=1 forces all counters to 0 that cycle, overriding any increment in the same cycle.
  - RESET overrides cnt_clr_i.
  - Counter updates are independent of the payload path; only the cycle's action decides increments.
- Only the action logic and counter increments are combinational; all outputs are registered.

Test Plan:
- Reset with Rst_n=1 for 2 cycles while in_valid_i=1, in_data_i=all-ones -> all outputs 0, state_o=0, counters 0. Release, then ADVANCE data 0xA5.. -> next cycle out_data_o=0xA5.., out_valid_o=1, state_o=1.
- STAGE=3, stall=6'b001111 for 3 cycles with carry_i stepping 1,2,3 -> out_valid_o=0, out_data_o=0, carry_o follows 1,2,3 one cycle late, bubble_cnt_o=3, stall_cycles_o=3.
- stall=6'b011111 for 2 cycles with FULL payload 0x1234 -> payload and valid held, state_o=2, carry_o tracks carry_i, stall_cycles_o +2. Then stall=0 -> new payload captured, state_o=1, carry_o=0.
- flush_i=1 together with stall=6'b011111 and carry_o nonzero -> next cycle out_valid_o=0, carry_o=0, state_o=0, flush_cnt_o=1, stall_cycles_o unchanged.
- CNT_W=3: 9 consecutive bubbles -> bubble_cnt_o saturates at 7. cnt_clr_i on a bubble cycle -> 0 next cycle.
- STAGE=5 (top bit), stall=6'b100000 -> treated as BUBBLE (s_dn=0), bubble_cnt_o increments. ADVANCE with in_valid_i=0, in_data_i=0xFF.. -> out_data_o=0.
